dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the CPU datapath and a debug/loader port.
- Inserts CPU stall cycles while a CPU load or store is pending.
- Serialises accesses through a small FSM.
- Drives a memory port with one-cycle read latency.
- Sits between the datapath's memory outputs (address, write data, read/write strobes) and the data memory instance.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_pick.sv | 34 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 64;
  localparam int DMEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } stateT;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } grantT;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-way requester picker; DMEM_ARB_RR_EN selects round-robin,
// otherwise fixed CPU priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic  req_cpu,
  input  logic  req_dbg,
  input  grantT last_grant,
  output grantT grant
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    grant = GNT_CPU;
    if (req_cpu && req_dbg) begin
      grant = (last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
    end else if (req_dbg) begin
      grant = GNT_DBG;
    end
  end
`else
  // Fixed priority has no use for history; the port stays for a uniform interface.
  logic unusedLastGrant;
  assign unusedLastGrant = (last_grant == GNT_DBG);

  always_comb begin
    grant = GNT_CPU;
    if (!req_cpu && req_dbg) begin
      grant = GNT_DBG;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-memory port between CPU and debug with stall
// insertion; DMEM_ARB_RR_EN enables round-robin arbitration.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  stateT             state;
  grantT             grant;
  grantT             pickGrant;
  grantT             lastGrant;
  logic              opWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic [DATA_W-1:0] cpuHold;
  logic [DATA_W-1:0] dbgHold;
  logic              cpuPend;
  logic              dbgPend;
  logic              anyPend;
  logic              issueCyc;
  logic              dataCyc;
  logic              doneCyc;
  logic              cpuDone;
  logic              dbgDone;
  logic              cpuData;
  logic              dbgData;

  assign cpuPend  = cpu_re | cpu_we;
  assign dbgPend  = dbg_req;
  assign anyPend  = cpuPend | dbgPend;
  assign issueCyc = (state == ISSUE);
  assign dataCyc  = (state == DATA);
  assign doneCyc  = (issueCyc && opWrite) || dataCyc;
  assign cpuDone  = doneCyc && (grant == GNT_CPU);
  assign dbgDone  = doneCyc && (grant == GNT_DBG);
  assign cpuData  = dataCyc && (grant == GNT_CPU);
  assign dbgData  = dataCyc && (grant == GNT_DBG);

  dmem_arb_pick uPick (
    .req_cpu    (cpuPend),
    .req_dbg    (dbgPend),
    .last_grant (lastGrant),
    .grant      (pickGrant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= GNT_CPU;
      opWrite  <= 1'b0;
      reqAddr  <= '0;
      reqWdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (anyPend) begin
            state <= ISSUE;
            grant <= pickGrant;
            if (pickGrant == GNT_DBG) begin
              opWrite  <= dbg_we;
              reqAddr  <= dbg_addr;
              reqWdata <= dbg_wdata;
            end else begin
              // re and we together resolve to a write
              opWrite  <= cpu_we;
              reqAddr  <= cpu_addr;
              reqWdata <= cpu_wdata;
            end
          end
        end
        ISSUE:   state <= opWrite ? IDLE : DATA;
        DATA:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant <= GNT_DBG;
    end else if ((state == IDLE) && anyPend) begin
      lastGrant <= pickGrant;
    end
  end
`else
  assign lastGrant = GNT_DBG;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cpuHold <= '0;
      dbgHold <= '0;
    end else begin
      if (cpuData) cpuHold <= mem_rdata;
      if (dbgData) dbgHold <= mem_rdata;
    end
  end

  // Everything is gated by rst so a mid-access reset goes quiet immediately.
  assign mem_addr  = (!rst && issueCyc) ? reqAddr : '0;
  assign mem_wdata = (!rst && issueCyc) ? reqWdata : '0;
  assign mem_we    = !rst && issueCyc && opWrite;
  assign mem_re    = !rst && issueCyc && !opWrite;
  assign cpu_stall = !rst && cpuPend && !cpuDone;
  assign dbg_ack   = !rst && dbgDone;
  assign cpu_rdata = rst ? '0 : (cpuData ? mem_rdata : cpuHold);
  assign dbg_rdata = rst ? '0 : (dbgData ? mem_rdata : dbgHold);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (either DMEM_ARB_RR_EN build)
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [63:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_we, cpu_re, dbg_req, dbg_we;
  logic [63:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ack, mem_we, mem_re;

  int total = 0;
  int bad = 0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency
  logic [63:0] memArr [0:255];
  logic [63:0] memRd;
  assign mem_rdata = memRd;
  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = '0;
    memRd = '0;
  end
  always @(posedge clk) begin
    if (mem_we) memArr[mem_addr[7:0]] <= mem_wdata;
    memRd <= memArr[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one access in flight, aged in cycles since its grant
  bit          mBusy = 0;
  bit          mWho = 0;       // 1 = debug owns the access
  bit          mWr = 0;
  int          mAge = 0;
  bit          mLastDbg = 1;
  logic [63:0] mAddr = '0, mWdata = '0, mCpuHold = '0, mDbgHold = '0;
  logic [63:0] refMem [0:255];
  initial for (int i = 0; i < 256; i++) refMem[i] = '0;

  always @(posedge clk) begin
    bit cpuP, takeDbg;
    cpuP = cpu_re | cpu_we;
    if (rst) begin
      mBusy = 0; mLastDbg = 1; mCpuHold = '0; mDbgHold = '0;
    end else if (mBusy) begin
      if (mAge == 1 && mWr) begin
        refMem[mAddr[7:0]] = mWdata;
        mBusy = 0;
      end else if (mAge == 1) begin
        mAge = 2;
      end else begin
        if (mWho) mDbgHold = refMem[mAddr[7:0]];
        else      mCpuHold = refMem[mAddr[7:0]];
        mBusy = 0;
      end
    end else if (cpuP || dbg_req) begin
`ifdef DMEM_ARB_RR_EN
      takeDbg = (cpuP && dbg_req) ? !mLastDbg : !cpuP;
`else
      takeDbg = !cpuP;
`endif
      mLastDbg = takeDbg;
      mWho = takeDbg;
      mWr = takeDbg ? dbg_we : cpu_we;
      mAddr = takeDbg ? dbg_addr : cpu_addr;
      mWdata = takeDbg ? dbg_wdata : cpu_wdata;
      mBusy = 1;
      mAge = 1;
    end
  end

  always @(negedge clk) begin
    bit iss, dat, done;
    logic [63:0] rd;
    iss = !rst && mBusy && mAge == 1;
    dat = !rst && mBusy && mAge == 2;
    done = (iss && mWr) || dat;
    rd = refMem[mAddr[7:0]];
    chk("mem_addr", mem_addr, iss ? mAddr : 64'd0);
    chk("mem_wdata", mem_wdata, iss ? mWdata : 64'd0);
    chk("mem_we", {63'd0, mem_we}, {63'd0, iss && mWr});
    chk("mem_re", {63'd0, mem_re}, {63'd0, iss && !mWr});
    chk("cpu_stall", {63'd0, cpu_stall}, {63'd0, !rst && (cpu_re | cpu_we) && !(done && !mWho)});
    chk("dbg_ack", {63'd0, dbg_ack}, {63'd0, done && mWho});
    chk("cpu_rdata", cpu_rdata, rst ? 64'd0 : ((dat && !mWho) ? rd : mCpuHold));
    chk("dbg_rdata", dbg_rdata, rst ? 64'd0 : ((dat && mWho) ? rd : mDbgHold));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lets whatever is still requesting complete, dropping each requester after its completion.
  task automatic finishPending();
    bit cpuLeft, dbgLeft;
    cpuLeft = cpu_re | cpu_we;
    dbgLeft = dbg_req;
    for (int i = 0; i < 12 && (cpuLeft || dbgLeft); i++) begin
      @(negedge clk);
      if (cpuLeft && !cpu_stall) cpuLeft = 0;
      if (dbgLeft && dbg_ack) dbgLeft = 0;
      step();
      if (!cpuLeft) begin cpu_re = 0; cpu_we = 0; end
      if (!dbgLeft) dbg_req = 0;
    end
    total++;
    if (cpuLeft || dbgLeft) begin
      bad++;
      $display("FAIL drain_timeout: cpu_left=%0d dbg_left=%0d expected 0 0", cpuLeft, dbgLeft);
    end
  endtask

  initial begin
    rst = 1; cpu_addr = '0; cpu_wdata = '0; cpu_re = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    cpu_we = 1;
    repeat (2) step();
    @(negedge clk); chk("rst_stall_forced", {63'd0, cpu_stall}, 64'd0);
    step();

    // CPU store
    rst = 0; cpu_we = 1; cpu_addr = 64'h10; cpu_wdata = 64'hDEAD;
    @(negedge clk); chk("st_stall_t", {63'd0, cpu_stall}, 64'd1);
    chk("st_we_t", {63'd0, mem_we}, 64'd0);
    step(); @(negedge clk);
    chk("st_we_t1", {63'd0, mem_we}, 64'd1);
    chk("st_addr_t1", mem_addr, 64'h10);
    chk("st_stall_t1", {63'd0, cpu_stall}, 64'd0);

    // CPU load of the same address
    step(); cpu_we = 0; cpu_re = 1;
    @(negedge clk); chk("ld_stall_t", {63'd0, cpu_stall}, 64'd1);
    step(); @(negedge clk);
    chk("ld_re_t1", {63'd0, mem_re}, 64'd1);
    chk("ld_stall_t1", {63'd0, cpu_stall}, 64'd1);
    step(); @(negedge clk);
    chk("ld_rdata_t2", cpu_rdata, 64'hDEAD);
    chk("ld_stall_t2", {63'd0, cpu_stall}, 64'd0);
    step(); cpu_re = 0;
    @(negedge clk); chk("ld_rdata_hold", cpu_rdata, 64'hDEAD);

    // Debug write, then req kept high as a new read request
    step(); dbg_req = 1; dbg_we = 1; dbg_addr = 64'h20; dbg_wdata = 64'h1234;
    @(negedge clk); chk("dw_ack_t", {63'd0, dbg_ack}, 64'd0);
    step(); @(negedge clk);
    chk("dw_ack_t1", {63'd0, dbg_ack}, 64'd1);
    chk("dw_addr_t1", mem_addr, 64'h20);
    step(); dbg_we = 0;
    @(negedge clk); chk("dr_ack_t", {63'd0, dbg_ack}, 64'd0);
    step(); @(negedge clk); chk("dr_re_t1", {63'd0, mem_re}, 64'd1);
    step(); @(negedge clk);
    chk("dr_ack_t2", {63'd0, dbg_ack}, 64'd1);
    chk("dr_rdata_t2", dbg_rdata, 64'h1234);
    step(); dbg_req = 0;
    @(negedge clk); chk("dr_rdata_hold", dbg_rdata, 64'h1234);

    // CPU with re and we both high behaves as a store
    step(); cpu_re = 1; cpu_we = 1; cpu_addr = 64'h60; cpu_wdata = 64'h77;
    step(); @(negedge clk);
    chk("rw_we", {63'd0, mem_we}, 64'd1);
    chk("rw_re", {63'd0, mem_re}, 64'd0);
    step(); cpu_we = 0;
    step(); step(); @(negedge clk);
    chk("rw_readback", cpu_rdata, 64'h77);
    step(); cpu_re = 0;

    // Simultaneous requests straight after reset
    rst = 1;
    step();
    rst = 0; cpu_we = 1; cpu_addr = 64'h30; cpu_wdata = 64'hA;
    dbg_req = 1; dbg_we = 1; dbg_addr = 64'h40; dbg_wdata = 64'hB;
    step(); @(negedge clk);
    chk("sim1_addr", mem_addr, 64'h30);
    chk("sim1_ack", {63'd0, dbg_ack}, 64'd0);
    step(); cpu_addr = 64'h50; cpu_wdata = 64'hC;
    step(); @(negedge clk);
`ifdef DMEM_ARB_RR_EN
    chk("sim2_addr", mem_addr, 64'h40);
    chk("sim2_ack", {63'd0, dbg_ack}, 64'd1);
    step(); dbg_req = 0;
`else
    chk("sim2_addr", mem_addr, 64'h50);
    chk("sim2_ack", {63'd0, dbg_ack}, 64'd0);
    step(); cpu_we = 0;
`endif
    finishPending();

    // Reset while a debug read sits in ISSUE
    dbg_req = 1; dbg_we = 0; dbg_addr = 64'h20;
    step(); rst = 1;
    @(negedge clk);
    chk("rsti_re", {63'd0, mem_re}, 64'd0);
    chk("rsti_ack", {63'd0, dbg_ack}, 64'd0);
    step(); rst = 0; dbg_req = 0;
    @(negedge clk);
    chk("rsto_ack", {63'd0, dbg_ack}, 64'd0);
    chk("rsto_rdata", dbg_rdata, 64'd0);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
